mm_copy_master: RTL and testbench

- Avalon-MM initiator (master) that copies a block of 32-bit words from a source region to a destination region through the system interconnect.
- It is the active end of the same bus on which the on-chip RAM and other slaves respond, so the serial/control logic can move buffers without the Nios CPU.
- Controlled by a start pulse plus address/length registers. Reports busy, a done pulse and a word count.
- Has at most one outstanding bus transaction at any time.

---
 rtl/mm_copy_master_pkg.sv | 23 ++
 rtl/mm_copy_master.sv | 150 +++++++++++++++
 tb/tb_mm_copy_master.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mm_copy_master_pkg.sv
/*----------------------------------------------------------------------------
 * Module   : mm_copy_master_pkg
 * Function : Shared state encoding and bus constants for mm_copy_master.
 * Revision : 1.0  initial release
 *--------------------------------------------------------------------------*/
`default_nettype none

package mm_copy_master_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    FINISH  = 3'd4
  } state_t;

  localparam logic [3:0] BE_ALL     = 4'hF;
  localparam int         WORD_BYTES = 4;

endpackage

`default_nettype wire

// File: rtl/mm_copy_master.sv
/*----------------------------------------------------------------------------
 * Module   : mm_copy_master
 * Function : Avalon-MM initiator copying a block of 32-bit words src -> dst,
 *            one outstanding transaction, ascending word order.
 * Revision : 1.0  initial release
 *--------------------------------------------------------------------------*/
`default_nettype none

module mm_copy_master
  import mm_copy_master_pkg::*;
#(
  parameter int ADDR_W = 14,
  parameter int LEN_W  = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len_words,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  words_done,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  output logic [3:0]        avm_byteenable,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid
);

  localparam logic [ADDR_W-1:0] C_ALIGN_MASK = ~ADDR_W'(WORD_BYTES - 1);
  localparam logic [ADDR_W-1:0] C_STEP       = ADDR_W'(WORD_BYTES);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0] r_dst;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_words_done;
  logic [31:0]       r_data;

  logic w_start_acc;
  logic w_wr_acc;
  logic w_capture;
  logic w_last;

  assign w_start_acc = (r_state == IDLE) && start;
  assign w_wr_acc    = (r_state == WR_REQ) && !avm_waitrequest;
  assign w_capture   = (r_state == RD_WAIT) && avm_readdatavalid;
  assign w_last      = (r_words_done + LEN_W'(1)) == r_len;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_next = (len_words == '0) ? FINISH : RD_REQ;
        end
      end
      RD_REQ: begin
        if (!avm_waitrequest) begin
          w_next = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (avm_readdatavalid) begin
          w_next = WR_REQ;
        end
      end
      WR_REQ: begin
        if (!avm_waitrequest) begin
          w_next = w_last ? FINISH : RD_REQ;
        end
      end
      FINISH:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Bus outputs are decoded from state so every field reads zero when idle.
  always_comb begin
    busy           = 1'b0;
    done           = 1'b0;
    avm_read       = 1'b0;
    avm_write      = 1'b0;
    avm_address    = '0;
    avm_writedata  = '0;
    avm_byteenable = '0;
    unique case (r_state)
      RD_REQ: begin
        busy           = 1'b1;
        avm_read       = 1'b1;
        avm_address    = r_src;
        avm_byteenable = BE_ALL;
      end
      RD_WAIT: busy = 1'b1;
      WR_REQ: begin
        busy           = 1'b1;
        avm_write      = 1'b1;
        avm_address    = r_dst;
        avm_writedata  = r_data;
        avm_byteenable = BE_ALL;
      end
      FINISH:  done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_src        <= '0;
      r_dst        <= '0;
      r_len        <= '0;
      r_words_done <= '0;
      r_data       <= '0;
    end else begin
      if (w_start_acc) begin
        r_src        <= src_addr & C_ALIGN_MASK;
        r_dst        <= dst_addr & C_ALIGN_MASK;
        r_len        <= len_words;
        r_words_done <= '0;
      end
      if (w_capture) begin
        r_data <= avm_readdata;
      end
      // Pointers wrap modulo 2^ADDR_W by natural overflow.
      if (w_wr_acc) begin
        r_src        <= r_src + C_STEP;
        r_dst        <= r_dst + C_STEP;
        r_words_done <= r_words_done + LEN_W'(1);
      end
    end
  end

  assign words_done = r_words_done;

endmodule

`default_nettype wire

// File: tb/tb_mm_copy_master.sv
/*----------------------------------------------------------------------------
 * Module   : tb_mm_copy_master
 * Function : Directed self-checking bench for mm_copy_master with an Avalon
 *            slave model (random waitrequest, variable read latency).
 * Revision : 1.0  initial release
 *--------------------------------------------------------------------------*/
`default_nettype none

module tb_mm_copy_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [13:0] src_addr;
  logic [13:0] dst_addr;
  logic [11:0] len_words;
  logic        busy;
  logic        done;
  logic [11:0] words_done;
  logic [13:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic        avm_waitrequest = 1'b0;
  logic [31:0] avm_readdata = '0;
  logic        avm_readdatavalid = 1'b0;

  int vectors     = 0;
  int miscompares = 0;

  mm_copy_master #(.ADDR_W(14), .LEN_W(12)) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .src_addr          (src_addr),
    .dst_addr          (dst_addr),
    .len_words         (len_words),
    .busy              (busy),
    .done              (done),
    .words_done        (words_done),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_write         (avm_write),
    .avm_writedata     (avm_writedata),
    .avm_byteenable    (avm_byteenable),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input int w);
    return 32'h1234_5678 ^ (32'(w) * 32'h9E37_79B9);
  endfunction

  // Avalon slave model: 4096-word memory, optional random stall, latency range.
  logic [31:0] mem [0:4095];
  logic        mem_init = 1'b0;
  logic        wait_en  = 1'b0;
  int          lat_min  = 1;
  int          lat_max  = 1;
  int          lat;
  int          pend     = 0;
  int          rd_cnt   = 0;
  int          wr_cnt   = 0;
  int          done_cnt = 0;
  int          stall_viol = 0;
  int          rw_both  = 0;
  int          be_viol  = 0;
  logic [13:0] rd_log [0:255];
  logic [13:0] wr_log [0:255];
  logic        prev_stall = 1'b0;
  logic [51:0] prev_sig   = '0;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 4096; i++) mem[i] <= pat(i);
    end
    avm_waitrequest   <= wait_en ? 1'($urandom_range(0, 1)) : 1'b0;
    avm_readdatavalid <= 1'b0;
    if (pend != 0) begin
      pend <= pend - 1;
      if (pend == 1) avm_readdatavalid <= 1'b1;
    end
    if (avm_read && !avm_waitrequest) begin
      lat = int'($urandom_range(lat_max, lat_min));
      avm_readdata <= mem[avm_address[13:2]];
      if (lat <= 1) avm_readdatavalid <= 1'b1;
      else pend <= lat - 1;
      rd_log[rd_cnt[7:0]] <= avm_address;
      rd_cnt <= rd_cnt + 1;
    end
    if (avm_write && !avm_waitrequest) begin
      mem[avm_address[13:2]] <= avm_writedata;
      wr_log[wr_cnt[7:0]] <= avm_address;
      wr_cnt <= wr_cnt + 1;
    end
    if (prev_stall &&
        {avm_read, avm_write, avm_address, avm_writedata, avm_byteenable} !== prev_sig)
      stall_viol <= stall_viol + 1;
    prev_stall <= (avm_read || avm_write) && avm_waitrequest && !reset;
    prev_sig   <= {avm_read, avm_write, avm_address, avm_writedata, avm_byteenable};
    if (avm_read && avm_write) rw_both <= rw_both + 1;
    if ((avm_read || avm_write) && avm_byteenable !== 4'hF) be_viol <= be_viol + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns at the negedge following the start-accepting edge.
  task automatic go(input logic [13:0] s, input logic [13:0] d, input logic [11:0] n);
    @(negedge clk);
    src_addr  = s;
    dst_addr  = d;
    len_words = n;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // k = number of clock edges after the accepting edge before done is seen.
  task automatic wait_done(output int k);
    k = 0;
    while (done !== 1'b1 && k < 3000) begin
      @(negedge clk);
      k++;
    end
  endtask

  int k, rb, wb, db;

  initial begin
    reset = 1'b1; start = 1'b0;
    src_addr = '0; dst_addr = '0; len_words = '0;
    mem_init = 1'b1;
    repeat (3) @(negedge clk);
    mem_init = 1'b0;

    check("rst_busy",       32'(busy), 0);
    check("rst_done",       32'(done), 0);
    check("rst_words_done", 32'(words_done), 0);
    check("rst_read",       32'(avm_read), 0);
    check("rst_write",      32'(avm_write), 0);
    check("rst_address",    32'(avm_address), 0);
    check("rst_writedata",  avm_writedata, 0);
    check("rst_be",         32'(avm_byteenable), 0);
    reset = 1'b0;

    // 1: four words, zero wait, latency 1 -> done rises 12 edges after start
    rb = rd_cnt; wb = wr_cnt; db = done_cnt;
    go(14'h000, 14'h800, 12'd4);
    check("t1_busy_after_start", 32'(busy), 1);
    wait_done(k);
    check("t1_done_latency", k, 12);
    check("t1_busy_at_done", 32'(busy), 0);
    check("t1_words_done", 32'(words_done), 4);
    @(negedge clk);
    check("t1_done_pulses", done_cnt - db, 1);
    check("t1_done_low", 32'(done), 0);
    check("t1_reads", rd_cnt - rb, 4);
    check("t1_writes", wr_cnt - wb, 4);
    for (int i = 0; i < 4; i++) check($sformatf("t1_mem%0d", i), mem[12'h200 + i], pat(i));
    check("t1_words_hold", 32'(words_done), 4);

    // 2: zero-length copy
    rb = rd_cnt; wb = wr_cnt; db = done_cnt;
    go(14'h010, 14'h810, 12'd0);
    wait_done(k);
    check("t2_done_latency", k, 0);
    check("t2_words_done", 32'(words_done), 0);
    repeat (2) @(negedge clk);
    check("t2_done_pulses", done_cnt - db, 1);
    check("t2_no_reads", rd_cnt - rb, 0);
    check("t2_no_writes", wr_cnt - wb, 0);

    // 3: random stalls, latency 1..5, 16 words
    wait_en = 1'b1; lat_min = 1; lat_max = 5;
    db = done_cnt;
    go(14'h100, 14'hC00, 12'd16);
    wait_done(k);
    check("t3_done_seen", 32'(done), 1);
    check("t3_words_done", 32'(words_done), 16);
    @(negedge clk);
    wait_en = 1'b0; lat_max = 1;
    repeat (2) @(negedge clk);
    check("t3_done_pulses", done_cnt - db, 1);
    for (int i = 0; i < 16; i++) check($sformatf("t3_mem%0d", i), mem[12'h300 + i], pat(12'h40 + i));
    check("t3_stall_stable", stall_viol, 0);
    check("t3_rw_exclusive", rw_both, 0);
    check("t3_byteenable", be_viol, 0);

    // 4: start while busy is ignored
    db = done_cnt;
    go(14'h200, 14'h400, 12'd8);
    repeat (3) @(negedge clk);
    go(14'h300, 14'h600, 12'd3);
    wait_done(k);
    check("t4_done_seen", 32'(done), 1);
    check("t4_words_done", 32'(words_done), 8);
    repeat (10) @(negedge clk);
    check("t4_done_pulses", done_cnt - db, 1);
    for (int i = 0; i < 8; i++) check($sformatf("t4_mem%0d", i), mem[12'h100 + i], pat(12'h80 + i));
    for (int i = 0; i < 3; i++) check($sformatf("t4_untouched%0d", i), mem[12'h180 + i], pat(12'h180 + i));

    // 5: address wrap; words 4095,0,1 copied to 4094,4095,0 in ascending order
    rb = rd_cnt; wb = wr_cnt;
    go(14'h3FFC, 14'h3FF8, 12'd3);
    wait_done(k);
    check("t5_done_seen", 32'(done), 1);
    @(negedge clk);
    check("t5_rd1_addr", 32'(rd_log[8'(rb + 1)]), 32'h0000);
    check("t5_wr1_addr", 32'(wr_log[8'(wb + 1)]), 32'h3FFC);
    check("t5_wr2_addr", 32'(wr_log[8'(wb + 2)]), 32'h0000);
    check("t5_mem4094", mem[4094], pat(4095));
    check("t5_mem4095", mem[4095], pat(0));
    check("t5_mem0",    mem[0],    pat(1));

    // 6: reset in RD_WAIT with read data still pending
    lat_min = 4; lat_max = 4;
    rb = rd_cnt; wb = wr_cnt;
    go(14'h040, 14'h900, 12'd4);
    k = 0;
    while (rd_cnt == rb && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("t6_read_issued", rd_cnt - rb, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t6_busy",       32'(busy), 0);
    check("t6_read",       32'(avm_read), 0);
    check("t6_write",      32'(avm_write), 0);
    check("t6_address",    32'(avm_address), 0);
    check("t6_be",         32'(avm_byteenable), 0);
    check("t6_words_done", 32'(words_done), 0);
    repeat (6) @(negedge clk);
    check("t6_no_write", wr_cnt - wb, 0);
    check("t6_idle", 32'({busy, avm_read, avm_write}), 0);
    lat_min = 1; lat_max = 1;
    go(14'h040, 14'h900, 12'd4);
    wait_done(k);
    check("t6_done_latency", k, 12);
    check("t6_words_done_after", 32'(words_done), 4);
    @(negedge clk);
    for (int i = 0; i < 4; i++) check($sformatf("t6_mem%0d", i), mem[12'h240 + i], pat(12'h10 + i));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
